// File: rtl/dilithium_stream_pkg.sv
// Shared types and frame-geometry helpers for the Dilithium output stream framer.
// Byte counts per operation/security level and the beat/keep arithmetic derived from them.
package dilithium_stream_pkg;

    typedef enum logic [1:0] {
        MODE_KEYGEN = 2'd0,
        MODE_SIGN   = 2'd1,
        MODE_VERIFY = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    localparam logic [2:0] SEC_L2 = 3'd2;
    localparam logic [2:0] SEC_L3 = 3'd3;
    localparam logic [2:0] SEC_L5 = 3'd5;

    localparam int MAX_FRAME_BYTES = 7456;
    localparam int KEEP_MAX        = 32;

    function automatic logic cfg_valid(input logic [1:0] mode, input logic [2:0] sec);
        return (mode != MODE_RSVD) && ((sec == SEC_L2) || (sec == SEC_L3) || (sec == SEC_L5));
    endfunction

    // Verify produces a single status beat, so it is sized as exactly one full word.
    function automatic int frame_bytes(input logic [1:0] mode, input logic [2:0] sec,
                                       input int data_w);
        int b;
        b = 0;
        case (mode)
            MODE_KEYGEN: begin
                case (sec)
                    SEC_L2:  b = 3840;
                    SEC_L3:  b = 5952;
                    SEC_L5:  b = 7456;
                    default: b = 0;
                endcase
            end
            MODE_SIGN: begin
                case (sec)
                    SEC_L2:  b = 2420;
                    SEC_L3:  b = 3293;
                    SEC_L5:  b = 4595;
                    default: b = 0;
                endcase
            end
            default: b = data_w / 8;
        endcase
        return b;
    endfunction

    function automatic int frame_beats(input int bytes, input int data_w);
        return (bytes * 8 + data_w - 1) / data_w;
    endfunction

    function automatic logic [KEEP_MAX-1:0] last_keep(input int bytes, input int data_w);
        logic [KEEP_MAX-1:0] k;
        int nb;
        int rem;
        nb  = data_w / 8;
        rem = bytes % nb;
        for (int i = 0; i < KEEP_MAX; i++) begin
            k[i] = (rem == 0) ? (i < nb) : (i < rem);
        end
        return k;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous beat buffer; storage is cleared on reset so the head reads zero
// until the first push.
module stream_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/dilithium_stream_framer.sv
// Frames one operation's output into an AXI-Stream packet: fixed beat count from
// mode/sec_lvl, FIFO-buffered beats, tlast and byte-accurate tkeep on the final beat.
//
//   state     | meaning
//   ST_IDLE   | waiting for start; invalid mode/sec_lvl pulses err
//   ST_STREAM | accepting core beats until len have been pushed
//   ST_DRAIN  | emptying the FIFO; done pulses after the last beat leaves
module dilithium_stream_framer
    import dilithium_stream_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [2:0]          sec_lvl,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_keep,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int FW     = DATA_W + KEEP_W + 1;

    if (DATA_W < 32 || DATA_W > 256 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
        $error("dilithium_stream_framer: DATA_W must be a power of two in 32..256");
    end

    if (longint'(frame_beats(MAX_FRAME_BYTES, DATA_W)) > (longint'(1) << LEN_W) - 1)
    begin : g_bad_len_w
        $error("dilithium_stream_framer: LEN_W too narrow for the longest frame");
    end

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    int                start_bytes;
    logic              push;
    logic              pop;
    logic              beat_last;
    logic [KEEP_W-1:0] beat_keep;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    assign start_bytes = frame_bytes(mode, sec_lvl, DATA_W);

    assign in_ready  = (state_q == ST_STREAM) && !fifo_full && (in_cnt_q < len_q);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign beat_last = (in_cnt_q == len_q - 1'b1);
    assign beat_keep = beat_last ? keep_q : '1;
    assign fifo_din  = {in_data, beat_last, beat_keep};

    stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout[FW-1 -: DATA_W];
    assign out_last  = fifo_dout[KEEP_W];
    assign out_keep  = fifo_dout[KEEP_W-1:0];
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            in_cnt_q <= '0;
            len_q    <= '0;
            keep_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            len_q    <= len_d;
            keep_q   <= keep_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        len_d    = len_q;
        keep_d   = keep_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_valid(mode, sec_lvl)) begin
                        len_d    = LEN_W'(frame_beats(start_bytes, DATA_W));
                        keep_d   = KEEP_W'(last_keep(start_bytes, DATA_W));
                        in_cnt_d = '0;
                        state_d  = ST_STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (push) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (beat_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The final beat is only pushed on the STREAM->DRAIN edge, so it always pops here.
                if (pop && out_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dilithium_stream_framer.sv
// Randomized bench for the stream framer: frames are checked beat-by-beat against
// a byte-count model of the expected packet.
module tb_dilithium_stream_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [1:0]  mode;
    logic [2:0]  sec_lvl;

    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy, done, err;
    logic [63:0] in_data, out_data;
    logic [7:0]  out_keep;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2, done2, err2;
    logic [31:0] in_data2, out_data2;
    logic [3:0]  out_keep2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] sent[$];
    logic [63:0] obs_data[$];
    logic [7:0]  obs_keep[$];
    logic        obs_last[$];
    int          stall_viol, max_occ, done_pulses, done_lat, last_hs_cyc, accepted;
    bit          timed_out;

    always #5 clk = ~clk;

    dilithium_stream_framer #(.DATA_W(64), .FIFO_DEPTH(4), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .sec_lvl(sec_lvl),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    dilithium_stream_framer #(.DATA_W(32), .FIFO_DEPTH(4), .LEN_W(16)) dut32 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode), .sec_lvl(sec_lvl),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_keep(out_keep2), .out_last(out_last2), .busy(busy2), .done(done2), .err(err2)
    );

    function automatic int model_bytes(input int m, input int s);
        int b;
        b = 0;
        if (m == 0) b = (s == 2) ? 3840 : (s == 3) ? 5952 : 7456;
        if (m == 1) b = (s == 2) ? 2420 : (s == 3) ? 3293 : 4595;
        if (m == 2) b = 8;
        return b;
    endfunction

    function automatic int model_len(input int bytes);
        return (bytes * 8 + 63) / 64;
    endfunction

    function automatic logic [7:0] model_keep(input int bytes);
        int r;
        r = bytes % 8;
        return (r == 0) ? 8'hFF : 8'((1 << r) - 1);
    endfunction

    task automatic fill_sent(input int n);
        sent.delete();
        for (int i = 0; i < n; i++) sent.push_back({$urandom(), $urandom()});
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [2:0] s);
        mode = m; sec_lvl = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'($urandom()); sec_lvl = 3'($urandom());
    endtask

    // Drives/observes one frame on the 64-bit instance; records what it saw, checks nothing.
    task automatic run_frame(input int n_send, input int bp_pct, input int v_pct,
                             input int stop_after);
        int k, occ;
        bit prev_stall, ended;
        logic [63:0] pd; logic [7:0] pk; logic pl;
        obs_data.delete(); obs_keep.delete(); obs_last.delete();
        stall_viol = 0; max_occ = 0; done_pulses = 0; done_lat = -1; last_hs_cyc = -1;
        k = 0; occ = 0; prev_stall = 0; ended = 0; pd = '0; pk = '0; pl = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            in_valid  = (k < n_send) && ($urandom_range(0, 99) < v_pct);
            in_data   = (k < n_send) ? sent[k] : 64'd0;
            out_ready = ($urandom_range(0, 99) >= bp_pct);
            @(negedge clk);
            if (prev_stall && (!out_valid || out_data !== pd || out_keep !== pk || out_last !== pl))
                stall_viol++;
            prev_stall = out_valid && !out_ready;
            pd = out_data; pk = out_keep; pl = out_last;
            if (done) begin
                done_pulses++;
                if (done_lat < 0) done_lat = cyc - last_hs_cyc;
            end
            if (out_valid && out_ready) begin
                obs_data.push_back(out_data); obs_keep.push_back(out_keep); obs_last.push_back(out_last);
                occ--;
                if (out_last) last_hs_cyc = cyc;
            end
            if (in_valid && in_ready) begin k++; occ++; end
            if (occ > max_occ) max_occ = occ;
            @(posedge clk); #1;
            if ((stop_after > 0 && obs_data.size() >= stop_after) ||
                (done_pulses > 0 && cyc - last_hs_cyc >= 3)) begin
                ended = 1; break;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        accepted = k; timed_out = !ended;
    endtask

    task automatic test_reset();
        rst = 1'b1; #1 rst = 1'b0; #11;
        n_cmp++;
        if ({in_ready, out_valid, out_last, busy, done, err, out_keep, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset64: got rdy=%b vld=%b last=%b busy=%b done=%b err=%b keep=%h data=%h want all 0",
                     in_ready, out_valid, out_last, busy, done, err, out_keep, out_data);
        end
        n_cmp++;
        if ({in_ready2, out_valid2, out_last2, busy2, done2, err2, out_keep2, out_data2} !== '0) begin
            n_fail++;
            $display("FAIL reset32: got keep=%h data=%h busy=%b want all 0", out_keep2, out_data2, busy2);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame_lengths();
        int tsec[3] = '{2, 3, 5};
        int bytes, len;
        logic [7:0] fk, ek;
        logic el;
        for (int t = 0; t < 3; t++) begin
            bytes = model_bytes(1, tsec[t]); len = model_len(bytes); fk = model_keep(bytes);
            fill_sent(len + 4);
            start_frame(2'd1, 3'(tsec[t]));
            run_frame(len + 4, 0, 100, 0);
            n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL sign%0d timeout: got 1 want 0", tsec[t]); end
            n_cmp++; if (accepted !== len) begin n_fail++; $display("FAIL sign%0d accepted: got %0d want %0d", tsec[t], accepted, len); end
            n_cmp++; if (obs_data.size() !== len) begin n_fail++; $display("FAIL sign%0d beats: got %0d want %0d", tsec[t], obs_data.size(), len); end
            for (int i = 0; i < obs_data.size() && i < len; i++) begin
                el = (i == len - 1); ek = el ? fk : 8'hFF;
                n_cmp++;
                if ({obs_data[i], obs_keep[i], obs_last[i]} !== {sent[i], ek, el}) begin
                    n_fail++;
                    $display("FAIL sign%0d beat %0d: got %h/%h/%b want %h/%h/%b", tsec[t], i,
                             obs_data[i], obs_keep[i], obs_last[i], sent[i], ek, el);
                end
            end
            n_cmp++; if (last_hs_cyc !== len) begin n_fail++; $display("FAIL sign%0d rate: last beat cycle %0d want %0d", tsec[t], last_hs_cyc, len); end
            n_cmp++; if (done_lat !== 1) begin n_fail++; $display("FAIL sign%0d done latency: got %0d want 1", tsec[t], done_lat); end
            n_cmp++; if (done_pulses !== 1) begin n_fail++; $display("FAIL sign%0d done pulses: got %0d want 1", tsec[t], done_pulses); end
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sign%0d busy after: got %b want 0", tsec[t], busy); end
        end
    endtask

    task automatic test_backpressure();
        int bytes, len;
        logic [7:0] fk, ek;
        logic el;
        bytes = model_bytes(0, 5); len = model_len(bytes); fk = model_keep(bytes);
        fill_sent(len + 4);
        start_frame(2'd0, 3'd5);
        run_frame(len + 4, 40, 85, 0);
        n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL bp timeout: got 1 want 0"); end
        n_cmp++; if (accepted !== len) begin n_fail++; $display("FAIL bp accepted: got %0d want %0d", accepted, len); end
        n_cmp++; if (obs_data.size() !== len) begin n_fail++; $display("FAIL bp beats: got %0d want %0d", obs_data.size(), len); end
        for (int i = 0; i < obs_data.size() && i < len; i++) begin
            el = (i == len - 1); ek = el ? fk : 8'hFF;
            n_cmp++;
            if ({obs_data[i], obs_keep[i], obs_last[i]} !== {sent[i], ek, el}) begin
                n_fail++;
                $display("FAIL bp beat %0d: got %h/%h/%b want %h/%h/%b", i,
                         obs_data[i], obs_keep[i], obs_last[i], sent[i], ek, el);
            end
        end
        n_cmp++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp stall stability: got %0d changes want 0", stall_viol); end
        n_cmp++; if (max_occ > 4) begin n_fail++; $display("FAIL bp occupancy: got %0d want <=4", max_occ); end
        n_cmp++; if (done_lat !== 1) begin n_fail++; $display("FAIL bp done latency: got %0d want 1", done_lat); end
        n_cmp++; if (done_pulses !== 1) begin n_fail++; $display("FAIL bp done pulses: got %0d want 1", done_pulses); end
    endtask

    task automatic test_verify32();
        int hs, beats, dn;
        logic [31:0] d, rd;
        logic [3:0] rk;
        logic rl;
        hs = 0; beats = 0; dn = 0; rd = '0; rk = '0; rl = 1'b0;
        d = $urandom();
        mode = 2'd2; sec_lvl = 3'd2; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; mode = 2'($urandom()); sec_lvl = 3'($urandom());
        in_valid2 = 1'b1; in_data2 = d;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            out_ready2 = (c >= 4);
            if (in_valid2 && in_ready2) hs++;
            if (out_valid2 && out_ready2) begin beats++; rd = out_data2; rk = out_keep2; rl = out_last2; end
            if (done2) dn++;
        end
        in_valid2 = 1'b0; out_ready2 = 1'b0;
        n_cmp++; if (hs !== 1) begin n_fail++; $display("FAIL v32 accepted: got %0d want 1", hs); end
        n_cmp++; if (beats !== 1) begin n_fail++; $display("FAIL v32 beats: got %0d want 1", beats); end
        n_cmp++;
        if ({rd, rk, rl} !== {d, 4'hF, 1'b1}) begin
            n_fail++; $display("FAIL v32 beat: got %h/%h/%b want %h/f/1", rd, rk, rl, d);
        end
        n_cmp++; if (dn !== 1) begin n_fail++; $display("FAIL v32 done pulses: got %0d want 1", dn); end
        n_cmp++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL v32 busy after: got %b want 0", busy2); end
        @(posedge clk); #1;
    endtask

    task automatic test_invalid();
        bit got_done;
        logic [1:0] bm[2] = '{2'd3, 2'd0};
        logic [2:0] bs[2] = '{3'd2, 3'd4};
        for (int t = 0; t < 2; t++) begin
            start_frame(bm[t], bs[t]);
            @(negedge clk);
            n_cmp++; if ({err, busy, in_ready} !== 3'b100) begin n_fail++; $display("FAIL invalid%0d pulse: got err/busy/rdy=%b%b%b want 100", t, err, busy, in_ready); end
            @(negedge clk);
            n_cmp++; if ({err, busy, in_ready} !== 3'b000) begin n_fail++; $display("FAIL invalid%0d after: got err/busy/rdy=%b%b%b want 000", t, err, busy, in_ready); end
            @(posedge clk); #1;
        end
        start_frame(2'd2, 3'd2);
        start_frame(2'd3, 3'd2);
        @(negedge clk);
        n_cmp++; if ({err, busy} !== 2'b01) begin n_fail++; $display("FAIL start while busy: got err/busy=%b%b want 01", err, busy); end
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = {$urandom(), $urandom()}; out_ready = 1'b1; got_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) begin got_done = 1; break; end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL verify64 done: got 0 want 1"); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        int bytes, len;
        logic [7:0] fk, ek;
        logic el;
        bytes = model_bytes(0, 2); len = model_len(bytes); fk = model_keep(bytes);
        fill_sent(len + 4);
        start_frame(2'd0, 3'd2);
        run_frame(len + 4, 20, 90, 100);
        n_cmp++; if (obs_data.size() !== 100 || busy !== 1'b1) begin n_fail++; $display("FAIL midframe pre: got beats=%0d busy=%b want 100/1", obs_data.size(), busy); end
        #2 rst = 1'b0; #1;
        n_cmp++;
        if ({in_ready, out_valid, out_last, busy, done, err, out_keep, out_data} !== '0) begin
            n_fail++;
            $display("FAIL midframe reset: got rdy=%b vld=%b last=%b busy=%b keep=%h data=%h want all 0",
                     in_ready, out_valid, out_last, busy, out_keep, out_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        fill_sent(len + 4);
        start_frame(2'd0, 3'd2);
        run_frame(len + 4, 0, 100, 0);
        n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL post-reset timeout: got 1 want 0"); end
        n_cmp++; if (obs_data.size() !== len) begin n_fail++; $display("FAIL post-reset beats: got %0d want %0d", obs_data.size(), len); end
        for (int i = 0; i < obs_data.size() && i < len; i++) begin
            el = (i == len - 1); ek = el ? fk : 8'hFF;
            n_cmp++;
            if ({obs_data[i], obs_keep[i], obs_last[i]} !== {sent[i], ek, el}) begin
                n_fail++;
                $display("FAIL post-reset beat %0d: got %h/%h/%b want %h/%h/%b", i,
                         obs_data[i], obs_keep[i], obs_last[i], sent[i], ek, el);
            end
        end
        n_cmp++; if (done_pulses !== 1) begin n_fail++; $display("FAIL post-reset done pulses: got %0d want 1", done_pulses); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0; start2 = 1'b0; mode = '0; sec_lvl = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        test_reset();
        test_frame_lengths();
        test_backpressure();
        test_verify32();
        test_invalid();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
